// File: rtl/read_word_uart_tx.sv
// read_word_uart_tx: buffers 16-bit PSRAM read words in a small FIFO and
// serializes each one as two 8N1 UART bytes, high byte first.
module read_word_uart_tx #(
  parameter int CLK_FREQ     = 27_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] read,
  input  logic        read_valid,
  output logic        read_ready,
  output logic        uart_tx,
  output logic        tx_busy,
  output logic        overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] BAUD_ONE  = BCW'(1);
  localparam logic [AW:0]    PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic        rst_meta_q;
  logic        rst_sync_q;
  logic        rst_n;

  logic [15:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;

  state_t          state_q, state_d;
  logic [15:0]     word_q, word_d;
  logic            byte_sel_q, byte_sel_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [BCW-1:0]  baud_cnt_q, baud_cnt_d;
  logic            uart_tx_q, uart_tx_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      cur_byte;
  logic [2:0]      next_bit_idx;

  // Reset synchronizer: assertion takes effect at once, release is aligned to sys_clk.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n = rst_sync_q;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = read_valid && !fifo_full;
  assign read_ready = !fifo_full;
  assign tx_busy    = (state_q != S_IDLE) || !fifo_empty;
  assign uart_tx    = uart_tx_q;
  assign overflow   = overflow_q;

  // Word storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= read;
    end
  end

  // Pointer advance and drop detection; full is judged before any same-cycle pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = read_valid && fifo_full;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Transmit sequencer: IDLE pops a word, then START/DATA/STOP run twice (high, low byte).
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    byte_sel_d   = byte_sel_q;
    bit_idx_d    = bit_idx_q;
    baud_cnt_d   = baud_cnt_q;
    uart_tx_d    = uart_tx_q;
    pop          = 1'b0;
    cur_byte     = byte_sel_q ? word_q[15:8] : word_q[7:0];
    next_bit_idx = bit_idx_q + 3'd1;

    case (state_q)
      S_IDLE: begin
        uart_tx_d = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          word_d     = mem_q[rd_ptr_q[AW-1:0]];
          byte_sel_d = 1'b1;
          state_d    = S_START;
          uart_tx_d  = 1'b0;
          baud_cnt_d = BAUD_LAST;
        end
      end
      S_START: begin
        if (baud_cnt_q == '0) begin
          state_d    = S_DATA;
          bit_idx_d  = 3'd0;
          uart_tx_d  = cur_byte[0];
          baud_cnt_d = BAUD_LAST;
        end else begin
          baud_cnt_d = baud_cnt_q - BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_cnt_q == '0) begin
          baud_cnt_d = BAUD_LAST;
          if (bit_idx_q == 3'd7) begin
            state_d   = S_STOP;
            uart_tx_d = 1'b1;
          end else begin
            bit_idx_d = next_bit_idx;
            uart_tx_d = cur_byte[next_bit_idx];
          end
        end else begin
          baud_cnt_d = baud_cnt_q - BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_cnt_q == '0) begin
          baud_cnt_d = BAUD_LAST;
          if (byte_sel_q) begin
            byte_sel_d = 1'b0;
            state_d    = S_START;
            uart_tx_d  = 1'b0;
          end else begin
            state_d   = S_IDLE;
            uart_tx_d = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - BAUD_ONE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        uart_tx_d = 1'b1;
      end
    endcase
  end

  // State register; reset idles the line high and empties the FIFO.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_IDLE;
      word_q     <= '0;
      byte_sel_q <= 1'b0;
      bit_idx_q  <= 3'd0;
      baud_cnt_q <= '0;
      uart_tx_q  <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      word_q     <= word_d;
      byte_sel_q <= byte_sel_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      uart_tx_q  <= uart_tx_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_read_word_uart_tx.sv
// tb_read_word_uart_tx: directed checks of read_word_uart_tx with a fast
// 10-cycle bit period, plus a default-parameter instance for the 234-cycle bit.
module tb_read_word_uart_tx;

  localparam int CPB  = 10;
  localparam int HALF = CPB / 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [15:0] read_word;
  logic        read_valid;
  logic        read_ready;
  logic        uart_tx;
  logic        tx_busy;
  logic        overflow;

  logic [15:0] def_read;
  logic        def_read_valid;
  logic        def_read_ready;
  logic        def_uart_tx;
  logic        def_tx_busy;
  logic        def_overflow;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int ovf_cnt = 0;

  logic [15:0] exp_words [5];

  read_word_uart_tx #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .read      (read_word),
    .read_valid(read_valid),
    .read_ready(read_ready),
    .uart_tx   (uart_tx),
    .tx_busy   (tx_busy),
    .overflow  (overflow)
  );

  read_word_uart_tx dut_def (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .read      (def_read),
    .read_valid(def_read_valid),
    .read_ready(def_read_ready),
    .uart_tx   (def_uart_tx),
    .tx_busy   (def_tx_busy),
    .overflow  (def_overflow)
  );

  // Free-running clock.
  always #5 sys_clk = ~sys_clk;

  // Cycle counter used for latency and length measurements.
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Tally every overflow pulse so drops can be counted over a whole test.
  always @(negedge sys_clk) if (overflow === 1'b1) ovf_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] w, input logic v);
    read_word  = w;
    read_valid = v;
    @(negedge sys_clk);
  endtask

  // Entered at the first cycle of a start bit; leaves at the first cycle after the stop bit.
  task automatic rxByte(output logic [7:0] b, output logic stop_bit);
    b = '0;
    repeat (HALF) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge sys_clk);
      b[i] = uart_tx;
    end
    repeat (CPB) @(negedge sys_clk);
    stop_bit = uart_tx;
    repeat (CPB - HALF) @(negedge sys_clk);
  endtask

  task automatic rxWord(input logic [15:0] exp_word, input string tag);
    int         t0;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       s_hi;
    logic       s_lo;
    t0 = cyc;
    checkOutput($sformatf("%s_start", tag), 32'(uart_tx), 32'd0);
    rxByte(hi, s_hi);
    checkOutput($sformatf("%s_lo_start", tag), 32'(uart_tx), 32'd0);
    rxByte(lo, s_lo);
    checkOutput($sformatf("%s_data", tag), 32'({hi, lo}), 32'(exp_word));
    checkOutput($sformatf("%s_stops", tag), 32'({s_hi, s_lo}), 32'd3);
    checkOutput($sformatf("%s_length", tag), 32'(cyc - t0), 32'(20 * CPB));
  endtask

  // Receive consecutive words, checking the single idle cycle between them.
  task automatic rxChain(input int first, input int n, input string tag);
    for (int i = first; i < first + n; i++) begin
      if (i != first) begin
        checkOutput($sformatf("%s_gap%0d", tag, i), 32'(uart_tx), 32'd1);
        @(negedge sys_clk);
      end
      rxWord(exp_words[i], $sformatf("%s_w%0d", tag, i));
    end
  endtask

  initial begin
    int   ovf_base;
    int   n;
    int   lows;
    logic prev;

    sys_rst_n      = 1'b0;
    read_word      = '0;
    read_valid     = 1'b0;
    def_read       = '0;
    def_read_valid = 1'b0;
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_hold_tx", 32'(uart_tx), 32'd1);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    checkOutput("rst_tx", 32'(uart_tx), 32'd1);
    checkOutput("rst_busy", 32'(tx_busy), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_ready", 32'(read_ready), 32'd1);

    $display("[TB] single word 0xA55A");
    applyStimulus(16'hA55A, 1'b1);
    checkOutput("t1_n1_tx", 32'(uart_tx), 32'd1);
    checkOutput("t1_n1_busy", 32'(tx_busy), 32'd1);
    applyStimulus(16'h0000, 1'b0);
    rxWord(16'hA55A, "t1");
    checkOutput("t1_idle_busy", 32'(tx_busy), 32'd0);
    checkOutput("t1_idle_tx", 32'(uart_tx), 32'd1);
    repeat (3) @(negedge sys_clk);

    $display("[TB] burst of four pushes behind a carrier word");
    exp_words = '{16'hC33C, 16'h0001, 16'h1234, 16'hFFFF, 16'h8000};
    applyStimulus(16'hC33C, 1'b1);
    applyStimulus(16'h0000, 1'b0);
    fork
      begin
        rxChain(0, 5, "t2");
        checkOutput("t2_idle_busy", 32'(tx_busy), 32'd0);
      end
      begin
        repeat (20) @(negedge sys_clk);
        checkOutput("t2_ready_before", 32'(read_ready), 32'd1);
        applyStimulus(16'h0001, 1'b1);
        applyStimulus(16'h1234, 1'b1);
        applyStimulus(16'hFFFF, 1'b1);
        applyStimulus(16'h8000, 1'b1);
        checkOutput("t2_ready_full", 32'(read_ready), 32'd0);
        applyStimulus(16'h0000, 1'b0);
      end
    join
    repeat (3) @(negedge sys_clk);

    $display("[TB] six pushes from idle, one dropped");
    exp_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    ovf_base  = ovf_cnt;
    fork
      begin
        applyStimulus(16'h1111, 1'b1);
        applyStimulus(16'h2222, 1'b1);
        applyStimulus(16'h3333, 1'b1);
        applyStimulus(16'h4444, 1'b1);
        applyStimulus(16'h5555, 1'b1);
        applyStimulus(16'h6666, 1'b1);
        checkOutput("t3_ovf_pulse", 32'(overflow), 32'd1);
        applyStimulus(16'h0000, 1'b0);
        checkOutput("t3_ovf_clear", 32'(overflow), 32'd0);
      end
      begin
        repeat (2) @(negedge sys_clk);
        rxChain(0, 5, "t3");
        checkOutput("t3_idle_busy", 32'(tx_busy), 32'd0);
        checkOutput("t3_idle_tx", 32'(uart_tx), 32'd1);
      end
    join
    checkOutput("t3_ovf_count", 32'(ovf_cnt - ovf_base), 32'd1);
    repeat (3) @(negedge sys_clk);

    $display("[TB] push while full on the pop cycle");
    exp_words = '{16'h7E81, 16'hBEEF, 16'hCAFE, 16'h0123, 16'h4567};
    ovf_base  = ovf_cnt;
    fork
      begin
        applyStimulus(16'h7E81, 1'b1);
        applyStimulus(16'hBEEF, 1'b1);
        applyStimulus(16'hCAFE, 1'b1);
        applyStimulus(16'h0123, 1'b1);
        applyStimulus(16'h4567, 1'b1);
        applyStimulus(16'h0000, 1'b0);
      end
      begin
        repeat (2) @(negedge sys_clk);
        rxWord(exp_words[0], "t4_w0");
        checkOutput("t4_ready_at_pop", 32'(read_ready), 32'd0);
        read_word  = 16'hDEAD;
        read_valid = 1'b1;
        @(negedge sys_clk);
        read_valid = 1'b0;
        checkOutput("t4_ovf_pulse", 32'(overflow), 32'd1);
        checkOutput("t4_ready_after", 32'(read_ready), 32'd1);
        rxChain(1, 4, "t4");
        checkOutput("t4_idle_busy", 32'(tx_busy), 32'd0);
      end
    join
    checkOutput("t4_ovf_count", 32'(ovf_cnt - ovf_base), 32'd1);
    repeat (3) @(negedge sys_clk);

    $display("[TB] reset during high-byte data");
    applyStimulus(16'h0000, 1'b1);
    applyStimulus(16'h1234, 1'b1);
    applyStimulus(16'h0000, 1'b0);
    repeat (30) @(negedge sys_clk);
    checkOutput("t5_pre_reset_low", 32'(uart_tx), 32'd0);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("t5_async_tx", 32'(uart_tx), 32'd1);
    checkOutput("t5_async_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checkOutput("t5_no_residual", 32'(lows), 32'd0);
    checkOutput("t5_busy_after", 32'(tx_busy), 32'd0);
    checkOutput("t5_ready_after", 32'(read_ready), 32'd1);

    $display("[TB] default parameters, word 0x55AA");
    def_read       = 16'h55AA;
    def_read_valid = 1'b1;
    @(negedge sys_clk);
    def_read_valid = 1'b0;
    @(negedge sys_clk);
    checkOutput("t6_start", 32'(def_uart_tx), 32'd0);
    prev = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      do begin
        @(negedge sys_clk);
        n++;
      end while (def_uart_tx === prev && n < 300);
      checkOutput($sformatf("t6_bit_period%0d", k), 32'(n), 32'd234);
      prev = def_uart_tx;
    end
    n = 0;
    while (def_tx_busy === 1'b1 && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("t6_word_end", 32'(n), 32'd2340);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
